issue_scoreboard: RTL and testbench
===================================

// Module: issue_scoreboard
// PURPOSE
//  Register-status scoreboard at the ID/issue boundary of the 5-stage RISC-V core; accepts ID issue requests.
//  - Tracks in-flight destination writes per architectural register and per-FU occupancy.
//  - Grants or refuses issue (valid/ready).
//  - Clears reservations on writeback or squash.
//  - Produces the RAW/WAW/structural stall reasons that the pipeline control consumes.
// PARAMETERS
//  NREG      32  architectural registers (x0 hard-wired zero)
//  NFU       4   functional units: 0=ALU 1=LSU 2=MUL 3=DIV
//  FU_W      2   width of FU tag (clog2 NFU)
//  OCC_MUL   1   cycles MUL is occupied per accepted op (1 = fully pipelined)
//  OCC_DIV   8   cycles DIV is occupied per accepted op (non-pipelined)
// PORTS
//  clk          in   1        core clock
//  rst          in   1        synchronous reset, active-high
//  id_valid     in   1        ID holds a decoded instruction
//  id_ready     out  1        scoreboard accepts it this cycle (combinational)
//  id_rs1       in   5        source 1 index
//  id_rs1use    in   1        source 1 is read
//  id_rs2       in   5        source 2 index
//  id_rs2use    in   1        source 2 is read
//  id_rd        in   5        destination index
//  id_rd_we     in   1        instruction writes rd
//  id_fu        in   FU_W     target functional unit
//  wb_valid     in   1        a write to wb_rd retires this cycle
//  wb_rd        in   5        retiring destination
//  wb_fu        in   FU_W     FU that produced it
//  kill_valid   in   1        squashed instruction releases its reservation
//  kill_rd      in   5        register to release
//  stall_raw    out  1        refusal cause: busy source
//  stall_waw    out  1        refusal cause: busy destination
//  stall_struct out  1        refusal cause: target FU occupied
//  busy_vec     out  NREG     registered busy bit per register
//  fu_busy      out  NFU      registered FU-occupied flags
//  sb_err       out  1        sticky: writeback tag mismatch or wb to non-busy reg
// BEHAVIOUR
//  - Reset: busy_vec=0, all tags=0, all occupancy counters=0, fu_busy=0, sb_err=0. id_ready=1 on first cycle after.
//  - eff_busy[r] = busy[r] & ~(wb_valid & wb_rd==r & tag[r]==wb_fu) & ~(kill_valid & kill_rd==r).
//    Same-cycle wb/kill bypass: the register file is write-first.
//  - stall_raw    = id_valid & ((id_rs1use & id_rs1!=0 & eff_busy[id_rs1]) | (same for rs2)).
//  - stall_waw    = id_valid & id_rd_we & id_rd!=0 & eff_busy[id_rd].
//  - stall_struct = id_valid & fu_busy[id_fu] (count in next cycle; no same-cycle release).
//  - id_ready = ~(stall_raw|stall_waw|stall_struct). All stall outputs are 0 when id_valid=0.
//  - Accept = id_valid & id_ready. On accept with id_rd_we & id_rd!=0: busy[id_rd]<=1, tag[id_rd]<=id_fu.
//  - Writeback: clears busy[wb_rd] only if busy & tag==wb_fu. Otherwise no state change, except sb_err<=1.
//    wb_rd==0 is ignored.
//  - Kill: clears busy[kill_rd] regardless of tag; kill of a non-busy register is a no-op.
//  - Priority on the same rd in one cycle: accept-set > kill/wb-clear. The new reservation survives.
//  - Occupancy: on accept to FU k with OCC_k>1, cnt[k]<=OCC_k-1. Nonzero cnt decrements by 1 per cycle.
//    fu_busy[k] = cnt[k]!=0. ALU/LSU (OCC=1) never report busy.
//  - Latency: a register reserved at cycle N shows in busy_vec at N+1. The earliest dependent accept is the cycle of its wb.
//  - busy[0] is constant 0. sb_err is cleared only by rst.
//  - rst mid-operation discards all reservations and counters. In-flight wbs after reset set sb_err, by design; the core flushes on reset.
// STRUCTURE
//  - pipe_ctrl_pkg holds: FU id constants (FU_ALU..FU_DIV), FU_W, REG_W=5, OCC table.
//    This package is shared with the hazard/forwarding unit and decode.
//  - Sub-module fu_occupancy_counter: one per FU, params OCC.
//    Ports clk, rst, start, busy. Instantiated with a generate loop.
//  - Busy/tag arrays and the stall logic stay in the top level.
// TESTING
//  1. Reset, then ID add x5<-x1,x2 (ALU) with id_valid=1 -> id_ready=1; next cycle busy_vec[5]=1.
//  2. x5 busy (tag ALU), ID reads x5 -> stall_raw=1, id_ready=0.
//     Then wb_valid with wb_rd=5, wb_fu=ALU in the same cycle -> id_ready=1 (bypass).
//  3. Accept DIV x7 -> fu_busy[3]=1 for exactly 7 cycles.
//     A second DIV is refused with stall_struct=1 for those 7 cycles and accepted on the 8th.
//  4. x9 busy (tag MUL), wb_rd=9 with wb_fu=DIV -> busy_vec[9] stays 1, sb_err=1 (sticky through later traffic).
//  5. Accept to rd=4 and kill_rd=4 in the same cycle (x4 previously busy) -> busy_vec[4]=1, tag = new FU.
//  6. Instruction with rd=0 and rs1=0 and x0 "busy" attempts -> never stalls, busy_vec[0]=0.
//     Also: rst asserted while DIV counter=5 -> next cycle fu_busy=0, busy_vec=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control constants: functional-unit ids, register index width
// and the per-FU occupancy table used by the issue scoreboard.
package pipe_ctrl_pkg;

  localparam int unsigned NREG  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned NFU   = 4;
  localparam int unsigned FU_W  = 2;

  typedef enum logic [FU_W-1:0] {
    FU_ALU = 2'd0,
    FU_LSU = 2'd1,
    FU_MUL = 2'd2,
    FU_DIV = 2'd3
  } fu_e;

  localparam int unsigned OCC_ALU = 1;
  localparam int unsigned OCC_LSU = 1;
  localparam int unsigned OCC_MUL = 1;
  localparam int unsigned OCC_DIV = 8;

  function automatic int unsigned occ_of(input int unsigned fu);
    case (fu)
      0:       occ_of = OCC_ALU;
      1:       occ_of = OCC_LSU;
      2:       occ_of = OCC_MUL;
      default: occ_of = OCC_DIV;
    endcase
  endfunction

endpackage

// File: rtl/fu_occupancy_counter.sv
// Down-counter holding a functional unit busy for OCC-1 cycles after an accepted op.
// Units with OCC=1 are fully pipelined and never report busy.
module fu_occupancy_counter #(
  parameter int unsigned OCC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  localparam int unsigned CNT_W = (OCC > 1) ? $clog2(OCC) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'((OCC > 1) ? (OCC - 1) : 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start && (OCC > 1)) begin
      cnt_d = LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/issue_scoreboard.sv
// Register-status scoreboard at the ID/issue boundary: tracks pending destination
// writes and FU occupancy, and grants or refuses issue with RAW/WAW/struct causes.
module issue_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic              id_rs1use,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic              id_rs2use,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_rd_we,
  input  logic [FU_W-1:0]   id_fu,
  input  logic              wb_valid,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [FU_W-1:0]   wb_fu,
  input  logic              kill_valid,
  input  logic [REG_W-1:0]  kill_rd,
  output logic              stall_raw,
  output logic              stall_waw,
  output logic              stall_struct,
  output logic [NREG-1:0]   busy_vec,
  output logic [NFU-1:0]    fu_busy,
  output logic              sb_err
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [FU_W-1:0] tag_q [NREG];
  logic [FU_W-1:0] tag_d [NREG];
  logic            sb_err_q, sb_err_d;

  logic [NREG-1:0] wb_hit, kill_hit, eff_busy;
  logic            accept;
  logic            wb_match;

  // Register file is write-first, so a same-cycle retire or squash already frees the register.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      wb_hit[r]   = wb_valid && (wb_rd == REG_W'(r)) && (tag_q[r] == wb_fu);
      kill_hit[r] = kill_valid && (kill_rd == REG_W'(r));
    end
    eff_busy = busy_q & ~wb_hit & ~kill_hit;
  end

  always_comb begin
    stall_raw    = id_valid &&
                   ((id_rs1use && (id_rs1 != '0) && eff_busy[id_rs1]) ||
                    (id_rs2use && (id_rs2 != '0) && eff_busy[id_rs2]));
    stall_waw    = id_valid && id_rd_we && (id_rd != '0) && eff_busy[id_rd];
    stall_struct = id_valid && fu_busy[id_fu];
    id_ready     = !(stall_raw || stall_waw || stall_struct);
    accept       = id_valid && id_ready;
  end

  // A new reservation overrides any clear of the same register in the same cycle.
  always_comb begin
    busy_d = eff_busy;
    tag_d  = tag_q;
    if (accept && id_rd_we && (id_rd != '0)) begin
      busy_d[id_rd] = 1'b1;
      tag_d[id_rd]  = id_fu;
    end
    busy_d[0] = 1'b0;

    wb_match = busy_q[wb_rd] && (tag_q[wb_rd] == wb_fu);
    sb_err_d = sb_err_q || (wb_valid && (wb_rd != '0) && !wb_match);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      sb_err_q <= 1'b0;
      for (int r = 0; r < NREG; r++) begin
        tag_q[r] <= '0;
      end
    end else begin
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
      tag_q    <= tag_d;
    end
  end

  for (genvar k = 0; k < NFU; k++) begin : g_fu
    fu_occupancy_counter #(
      .OCC (occ_of(k))
    ) u_occ (
      .clk   (clk),
      .rst   (rst),
      .start (accept && (id_fu == FU_W'(k))),
      .busy  (fu_busy[k])
    );
  end

  assign busy_vec = busy_q;
  assign sb_err   = sb_err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: a per-register/per-FU behavioural model checked
// every cycle, plus hand-computed literal expectations along the scenario.
module tb_issue_scoreboard;

  localparam logic [1:0] ALU = 2'd0;
  localparam logic [1:0] LSU = 2'd1;
  localparam logic [1:0] MUL = 2'd2;
  localparam logic [1:0] DIV = 2'd3;
  localparam int OCC_TB [4] = '{1, 1, 1, 8};

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1use, id_rs2use, id_rd_we;
  logic [1:0]  id_fu;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_fu;
  logic        kill_valid;
  logic [4:0]  kill_rd;
  logic        stall_raw, stall_waw, stall_struct;
  logic [31:0] busy_vec;
  logic [3:0]  fu_busy;
  logic        sb_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  issue_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_rs1       (id_rs1),
    .id_rs1use    (id_rs1use),
    .id_rs2       (id_rs2),
    .id_rs2use    (id_rs2use),
    .id_rd        (id_rd),
    .id_rd_we     (id_rd_we),
    .id_fu        (id_fu),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_fu        (wb_fu),
    .kill_valid   (kill_valid),
    .kill_rd      (kill_rd),
    .stall_raw    (stall_raw),
    .stall_waw    (stall_waw),
    .stall_struct (stall_struct),
    .busy_vec     (busy_vec),
    .fu_busy      (fu_busy),
    .sb_err       (sb_err)
  );

  // Model: which registers await a write and from which unit; remaining busy cycles per unit.
  bit [31:0] m_busy;
  int        m_tag [32];
  int        m_cnt [4];
  bit        m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit pending(input int r);
    if (r == 0 || !m_busy[r]) return 1'b0;
    if (wb_valid && int'(wb_rd) == r && m_tag[r] == int'(wb_fu)) return 1'b0;
    if (kill_valid && int'(kill_rd) == r) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_raw();
    return id_valid && ((id_rs1use && pending(int'(id_rs1))) ||
                        (id_rs2use && pending(int'(id_rs2))));
  endfunction

  function automatic bit exp_waw();
    return id_valid && id_rd_we && pending(int'(id_rd));
  endfunction

  function automatic bit exp_struct();
    return id_valid && (m_cnt[id_fu] > 0);
  endfunction

  function automatic bit [3:0] exp_fu_busy();
    bit [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = (m_cnt[k] > 0);
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy = '0;
      m_err  = 1'b0;
      for (int r = 0; r < 32; r++) m_tag[r] = 0;
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    end else begin
      bit acc;
      acc = id_valid && !(exp_raw() || exp_waw() || exp_struct());
      for (int k = 0; k < 4; k++) if (m_cnt[k] > 0) m_cnt[k]--;
      if (wb_valid && wb_rd != 0) begin
        if (m_busy[wb_rd] && m_tag[wb_rd] == int'(wb_fu)) m_busy[wb_rd] = 1'b0;
        else m_err = 1'b1;
      end
      if (kill_valid && kill_rd != 0) m_busy[kill_rd] = 1'b0;
      if (acc) begin
        if (id_rd_we && id_rd != 0) begin
          m_busy[id_rd] = 1'b1;
          m_tag[id_rd]  = int'(id_fu);
        end
        if (OCC_TB[id_fu] > 1) m_cnt[id_fu] = OCC_TB[id_fu] - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_stall_raw",    stall_raw,    exp_raw());
      chk("m_stall_waw",    stall_waw,    exp_waw());
      chk("m_stall_struct", stall_struct, exp_struct());
      chk("m_id_ready",     id_ready,     !(exp_raw() || exp_waw() || exp_struct()));
      chk("m_busy_vec",     busy_vec,     m_busy);
      chk("m_fu_busy",      fu_busy,      exp_fu_busy());
      chk("m_sb_err",       sb_err,       m_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs1use = 0; id_rs2 = 0; id_rs2use = 0;
    id_rd = 0; id_rd_we = 0; id_fu = ALU;
    wb_valid = 0; wb_rd = 0; wb_fu = ALU;
    kill_valid = 0; kill_rd = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic we, input logic [1:0] fu);
    id_valid = 1; id_rs1 = rs1; id_rs1use = u1; id_rs2 = rs2; id_rs2use = u2;
    id_rd = rd; id_rd_we = we; id_fu = fu;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [1:0] fu);
    wb_valid = 1; wb_rd = rd; wb_fu = fu;
  endtask

  initial begin
    rst = 1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst_busy_vec", busy_vec, 0);
    chk("rst_fu_busy",  fu_busy,  0);
    chk("rst_sb_err",   sb_err,   0);
    chk("rst_id_ready", id_ready, 1);

    // add x5 <- x1, x2
    step(); issue(1, 1, 2, 1, 5, 1, ALU);
    @(negedge clk); chk("add_ready", id_ready, 1);
    step(); idle();
    @(negedge clk); chk("add_busy5", busy_vec[5], 1);

    // RAW on x5, then released by a same-cycle writeback
    step(); issue(5, 1, 0, 0, 6, 1, ALU);
    @(negedge clk); chk("raw_stall", stall_raw, 1); chk("raw_ready", id_ready, 0);
    step(); wb(5, ALU);
    @(negedge clk); chk("bypass_ready", id_ready, 1); chk("bypass_raw", stall_raw, 0);
    step(); idle();
    @(negedge clk); chk("bypass_busy5", busy_vec[5], 0); chk("bypass_busy6", busy_vec[6], 1);
    step(); wb(6, ALU);
    step(); idle();

    // DIV occupancy: 7 refused cycles, accepted on the 8th
    step(); issue(0, 0, 0, 0, 7, 1, DIV);
    @(negedge clk); chk("div1_ready", id_ready, 1);
    step(); issue(0, 0, 0, 0, 8, 1, DIV);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("div_struct", stall_struct, 1);
      chk("div_fu_busy", fu_busy[3], 1);
      chk("div_ready_lo", id_ready, 0);
      step();
    end
    @(negedge clk); chk("div2_ready", id_ready, 1); chk("div2_struct", stall_struct, 0);
    step(); idle();
    @(negedge clk); chk("div2_fu_busy", fu_busy, 4'b1000);

    // WAW on x7 (tag DIV), released by matching writeback
    step(); issue(0, 0, 0, 0, 7, 1, ALU);
    @(negedge clk); chk("waw_stall", stall_waw, 1); chk("waw_ready", id_ready, 0);
    step(); wb(7, DIV);
    @(negedge clk); chk("waw_bypass_ready", id_ready, 1);
    step(); idle(); wb(7, ALU);
    step(); idle(); wb(8, DIV);
    step(); idle();

    // accept and kill of x4 in the same cycle: new MUL reservation survives
    step(); issue(0, 0, 0, 0, 4, 1, LSU);
    step(); issue(0, 0, 0, 0, 4, 1, MUL); kill_valid = 1; kill_rd = 4;
    @(negedge clk); chk("kill_ready", id_ready, 1); chk("kill_waw", stall_waw, 0);
    step(); idle();
    @(negedge clk); chk("kill_busy4", busy_vec[4], 1);
    step(); wb(4, MUL);
    step(); idle();
    @(negedge clk); chk("kill_tag_mul", busy_vec[4], 0); chk("kill_err", sb_err, 0);

    // x0 never reserves or stalls
    step(); issue(0, 0, 0, 0, 0, 1, ALU);
    @(negedge clk); chk("x0_ready_a", id_ready, 1);
    step(); issue(0, 1, 0, 1, 0, 1, MUL);
    @(negedge clk); chk("x0_ready_b", id_ready, 1); chk("x0_raw", stall_raw, 0);
    step(); idle(); wb(0, DIV);
    @(negedge clk); chk("x0_busy0", busy_vec[0], 0);
    step(); idle();
    @(negedge clk); chk("x0_wb_err", sb_err, 0);

    // tag-mismatched writeback on x9
    step(); issue(0, 0, 0, 0, 9, 1, MUL);
    step(); idle(); wb(9, DIV);
    @(negedge clk); chk("mis_busy9_pre", busy_vec[9], 1);
    step(); idle();
    @(negedge clk); chk("mis_busy9", busy_vec[9], 1); chk("mis_err", sb_err, 1);
    step(); wb(9, MUL); issue(9, 1, 0, 0, 3, 1, ALU);
    @(negedge clk); chk("mis_bypass_ready", id_ready, 1);
    step(); idle();
    @(negedge clk); chk("mis_busy9_clr", busy_vec[9], 0); chk("mis_err_sticky", sb_err, 1);
    step(); wb(3, ALU);
    step(); idle();

    // reset while DIV counter holds 5
    step(); issue(0, 0, 0, 0, 10, 1, DIV);
    @(negedge clk); chk("rdiv_ready", id_ready, 1);
    step(); idle();
    step();
    step(); rst = 1;
    @(negedge clk); chk("rdiv_fu_busy_pre", fu_busy[3], 1); chk("rdiv_busy10_pre", busy_vec[10], 1);
    step(); rst = 0;
    @(negedge clk);
    chk("rdiv_fu_busy", fu_busy, 0);
    chk("rdiv_busy_vec", busy_vec, 0);
    chk("rdiv_err", sb_err, 0);
    chk("rdiv_ready_post", id_ready, 1);
    step(); wb(10, DIV);
    step(); idle();
    @(negedge clk); chk("post_rst_wb_err", sb_err, 1);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
